// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO pair
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   start      launch the operation selected by op on rs_val/rt_val
//   op         2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
//   rs_val     multiplicand / dividend
//   rt_val     multiplier / divisor
//   hi_we      MTHI: write wdata to HI (idle only)
//   lo_we      MTLO: write wdata to LO (idle only)
//   wdata      MTHI/MTLO data
//   read_hilo  MFHI/MFLO in EX this cycle
//   hi, lo     registered HI/LO
//   busy       operation in flight
//   done       one-cycle pulse after HI/LO take a new result
//   stall      busy and the pipeline is touching the unit
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             read_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Launch decode: signed ops work on magnitudes, sign fixed up in FIX.
  logic             op_signed;
  logic             op_div;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  assign op_signed = ~op[0];
  assign op_div    = op[1];
  assign rs_mag    = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // Multiply step: work_q = {acc, multiplier}; add the multiplicand when the
  // multiplier LSB is set, then shift the 65-bit {carry, acc, mplier} right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                 + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // Divide step: work_q = {remainder, dividend/quotient}. The shifted partial
  // remainder is WIDTH+1 bits so the compare keeps the carry; when it is
  // >= divisor the true difference is < divisor, so the low WIDTH bits of a
  // wrapping subtract are exact.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  assign div_shift = work_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];

  // Sign correction. Divide by zero leaves quotient all ones by force; the
  // remainder naturally ends up as the dividend magnitude, and restoring the
  // dividend sign returns rs_val unchanged.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = neg_res_q ? -work_q : work_q;
  assign quo_fix  = div_zero_q ? {WIDTH{1'b1}}
                  : (neg_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0]);
  assign rem_fix  = neg_rem_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    work_d     = work_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // start wins over MTHI/MTLO in the same cycle
          state_d    = S_CALC;
          count_d    = '0;
          is_div_d   = op_div;
          neg_res_d  = op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          neg_rem_d  = op_signed & rs_val[WIDTH-1];
          div_zero_d = (rt_val == '0);
          if (op_div) begin
            opnd_d = rt_mag;
            work_d = {{WIDTH{1'b0}}, rs_mag};
          end else begin
            opnd_d = rs_mag;
            work_d = {{WIDTH{1'b0}}, rt_mag};
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      S_CALC: begin
        if (is_div_q) work_d = {div_rem, work_q[WIDTH-2:0], div_ge};
        else          work_d = {mul_sum, work_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      work_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      work_q     <= work_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | read_hilo | hi_we | lo_we);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        read_hilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .read_hilo (read_hilo),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI, LO} straight from MIPS semantics.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  // Model: idle or counting down the 33 cycles of an accepted operation.
  int          m_left = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_res  = '0;
  bit          m_done = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_res  <= ref_result(op, rs_val, rt_val);
          m_left <= 33;
        end else begin
          if (hi_we) m_hi <= wdata;
          if (lo_we) m_lo <= wdata;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
      check("cyc_busy", busy, m_left != 0);
      check("cyc_done", done, m_done);
      check("cyc_stall", stall, (m_left != 0) && (start || read_hilo || hi_we || lo_we));
    end
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int busy_n;
    int done_n;
    check({name, "_model"}, ref_result(o, a, b), {exp_hi, exp_lo});
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
    end
    check({name, "_busy_cycles"}, busy_n, 33);
    check({name, "_done_cycles"}, done_n, 1);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int done_n;
    reset = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; read_hilo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);

    run_op("mult_neg",   2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_min",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_neg",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negdv",  2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",       2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
    run_op("divu_zero",  2'b11, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    run_op("div_zero",   2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Pipeline traffic while busy must stall and leave HI/LO alone.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; rs_val = 32'hFFFFFFFD; rt_val = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    read_hilo = 1'b1;
    @(negedge clk);
    check("stall_read", stall, 1'b1);
    @(posedge clk); #1;
    read_hilo = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    check("stall_mthi", stall, 1'b1);
    @(posedge clk); #1;
    hi_we = 1'b0; start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    check("stall_start", stall, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done && guard < 40);
    check("busy_ops_done_seen", done, 1'b1);
    check("busy_ops_hi", hi, 32'hFFFFFFFF);
    check("busy_ops_lo", lo, 32'hFFFFFFF1);
    @(posedge clk); #1;
    read_hilo = 1'b1;
    @(negedge clk);
    check("mfhi_after_done_stall", stall, 1'b0);
    check("mfhi_after_done_hi", hi, 32'hFFFFFFFF);
    @(posedge clk); #1;
    read_hilo = 1'b0; lo_we = 1'b1; wdata = 32'hBEEF;
    @(posedge clk); #1;
    lo_we = 1'b0;
    @(negedge clk);
    check("mtlo_lo", lo, 32'hBEEF);
    check("mtlo_hi_kept", hi, 32'hFFFFFFFF);

    // Reset in the middle of a multiply discards it.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; rs_val = 32'd7; rt_val = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", busy, 1'b0);
    check("midreset_hi", hi, 32'h0);
    check("midreset_lo", lo, 32'h0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("midreset_no_done", done_n, 0);
    run_op("after_reset", 2'b00, 32'd7, 32'd9, 32'd0, 32'd63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
